// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: 32-step shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: multiplies leave RUN as soon as the remaining multiplier is zero.
module mdu_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int CW = $clog2(ITER);
  localparam logic [2:0] OP_NOP = 3'd0, OP_MULT = 3'd1, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_RSVD = 3'd7;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t        state;
  logic          is_div, is_signed, neg_q, neg_r;
  logic [63:0]   x;    // multiplicand (mult) / divisor in [31:0] (div)
  logic [63:0]   acc;  // product (mult) / partial remainder in [31:0] (div)
  logic [31:0]   y;    // multiplier (mult) / dividend shifting into quotient (div)
  logic [CW-1:0] count;

  logic        accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shl, diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        last_iter, early_done;

  assign accept  = start & ~busy & (op != OP_NOP) & (op != OP_RSVD);
  assign stall   = busy & (start | rd_req);
  assign rd_data = rd_sel ? hi : lo;

  always_comb begin
    abs_a     = (is_signed & y[31]) ? -y : y;
    abs_b     = (is_signed & x[31]) ? -x[31:0] : x[31:0];
    shl       = {acc[31:0], y[31]};
    diff      = shl - {1'b0, x[31:0]};
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -y : y;
    rem_fix   = neg_r ? -acc[31:0] : acc[31:0];
    last_iter = (count == CW'(ITER - 1));
`ifdef MDU_EARLY_OUT_EN
    early_done = ~is_div & (y[31:1] == 31'd0);
`else
    early_done = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      x         <= '0;
      acc       <= '0;
      y         <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: begin
                is_div    <= (op == OP_DIV) || (op == OP_DIVU);
                is_signed <= (op == OP_MULT) || (op == OP_DIV);
                y         <= a;
                x         <= {32'd0, b};
                busy      <= 1'b1;
                state     <= PREP;
              end
            endcase
          end
        end
        PREP: begin
          neg_q <= is_signed & (y[31] ^ x[31]);
          neg_r <= is_signed & y[31];
          acc   <= '0;
          count <= '0;
          if (is_div) begin
            y <= abs_a;
            x <= {32'd0, abs_b};
          end else begin
            x <= {32'd0, abs_a};
            y <= abs_b;
          end
          state <= RUN;
`ifdef MDU_EARLY_OUT_EN
          if (!is_div && abs_b == 32'd0) state <= FIX;
`endif
        end
        RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            // restoring step: keep the trial difference only when it did not borrow
            acc[31:0] <= diff[32] ? shl[31:0] : diff[31:0];
            y         <= {y[30:0], ~diff[32]};
          end else begin
            if (y[0]) acc <= acc + x;
            x <= x << 1;
            y <= y >> 1;
          end
          if (last_iter || early_done) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic        start;
  logic [31:0] a, b;
  logic        rd_req, rd_sel;
  logic [31:0] rd_data, hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mdu_seq #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .a(a), .b(b),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result as {hi, lo}
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    p = '0;
    case (o)
      3'd1: begin q = sa * sb; p = q; end
      3'd2: p = {32'd0, av} * {32'd0, bv};
      3'd3: begin
        if (bv == 0) p = {av, (av[31] ? 32'h1 : 32'hFFFFFFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (bv == 0) p = {av, 32'hFFFFFFFF};
        else p = {av % bv, av / bv};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] bv);
    logic [31:0] mb;
    int k;
    k = 0;
    mb = (o == 3'd1 && bv[31]) ? -bv : bv;
    for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
`ifdef MDU_EARLY_OUT_EN
    if (o == 3'd1 || o == 3'd2) return 2 + k;
`endif
    return 34 + 0 * k;
  endfunction

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; m_left <= 0;
    end else begin
      m_done <= 0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_hi <= m_phi; m_lo <= m_plo; m_busy <= 0; m_done <= 1; m_left <= 0;
        end else m_left <= m_left - 1;
      end else if (start && op >= 3'd1 && op <= 3'd6) begin
        if (op == 3'd5) m_hi <= a;
        else if (op == 3'd6) m_lo <= a;
        else begin
          {m_phi, m_plo} <= model_res(op, a, b);
          m_left <= model_lat(op, b);
          m_busy <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("stall", stall, m_busy & (start | rd_req));
      check("rd_data", rd_data, rd_sel ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 100);
    if (n >= 100) check("wait_done_timeout", 1, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [63:0] r;
    rst = 1; start = 0; op = 0; a = 0; b = 0; rd_req = 0; rd_sel = 0;
    tick(); tick();
    rst = 0; cmp_en = 1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);

    r = model_res(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("model_div_wrap", r, 64'h00000000_80000000);
    r = model_res(3'd3, 32'hFFFFFFF9, 32'h0);
    check("model_div_by0_neg", r, 64'hFFFFFFF9_00000001);

    // MULTU full-width
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    check("multu_busy_cycles", n, 34);
    check("multu_done", done, 1);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    tick();
    check("multu_done_once", done, 0);

    // MULT -3 * 5
    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    wait_done(n);
`ifdef MDU_EARLY_OUT_EN
    check("mult_latency", n, 5);
`else
    check("mult_latency", n, 34);
`endif
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    check("div_lat", n, 34);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd0);
    wait_done(n);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    check("divu0_hi", hi, 32'd7);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    check("div_wrap_lo", lo, 32'h80000000);
    check("div_wrap_hi", hi, 32'h0);

    // Held DIVU start, ignored MTLO, stalled reads
    op = 3'd4; a = 32'd100; b = 32'd7; start = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_held_start", stall, 1);
      tick();
    end
    op = 3'd6; a = 32'hDEADBEEF;
    check("stall_mtlo", stall, 1);
    tick();
    start = 0; rd_req = 1; rd_sel = 1;
    n = 0;
    while (busy && n < 100) begin
      check("stall_rd", stall, 1);
      n++;
      tick();
    end
    check("stall_exit_busy", busy, 0);
    check("stall_after", stall, 0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi_rd", rd_data, 32'd2);
    rd_req = 0; rd_sel = 0;

    // MTHI then reset mid-multiply
    issue(3'd5, 32'h12345678, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    issue(3'd1, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 40; i++) begin
      check("rst_no_done", done, 0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      rd_sel = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1));
      start = 1;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
      start = 0;
      if ($urandom_range(0, 60) == 0) begin
        rst = 1; tick(); rst = 0;
      end
      for (int j = 0; j < int'($urandom_range(0, 40)); j++) begin
        rd_req = 1'($urandom_range(0, 1));
        rd_sel = 1'($urandom_range(0, 1));
        tick();
      end
    end
    rd_req = 0;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    check("final_idle", busy, 0);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
